// File: rtl/board_game_pkg.sv
// Shared types for the gomoku board controller: cell colours, top FSM states,
// scan directions and the per-direction (drow, dcol) step table.
package board_game_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10,
    DRAW  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    CHECK = 2'b01,
    OVER  = 2'b10
  } state_t;

  // Scan order: horizontal, vertical, diagonal (+1,+1), anti-diagonal (+1,-1).
  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_t;

  typedef struct packed {
    logic signed [1:0] drow;
    logic signed [1:0] dcol;
  } offset_t;

  // Unit step of the positive half of each direction; the negative half negates it.
  function automatic offset_t dir_offset(input dir_t d);
    offset_t o;
    o.drow = 2'sd0;
    o.dcol = 2'sd1;
    unique case (d)
      DIR_H: begin o.drow = 2'sd0; o.dcol = 2'sd1;  end
      DIR_V: begin o.drow = 2'sd1; o.dcol = 2'sd0;  end
      DIR_D: begin o.drow = 2'sd1; o.dcol = 2'sd1;  end
      DIR_A: begin o.drow = 2'sd1; o.dcol = -2'sd1; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/board_game_fsm_win_scanner.sv
// Sequential line checker: walks outward from the placed cell one neighbour per
// cycle, four directions with a positive and a negative half each, and reports
// done/win. The cell under rd_addr_o must be returned combinationally on rd_data_i.
module win_scanner
  import board_game_pkg::*;
#(
  parameter int BOARD_W = 6,
  parameter int BOARD_H = 6,
  parameter int WIN_LEN = 5,
  parameter int RW      = $clog2(BOARD_H),
  parameter int CW      = $clog2(BOARD_W),
  parameter int AW      = $clog2(BOARD_W * BOARD_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [RW-1:0] origin_row_i,
  input  logic [CW-1:0] origin_col_i,
  input  cell_t         colour_i,
  input  cell_t         rd_data_i,
  output logic [AW-1:0] rd_addr_o,
  output logic          done_o,
  output logic          win_o
);

  localparam int DW = $clog2(WIN_LEN + 1);

  logic          active_q, active_d;
  dir_t          dir_q, dir_d;
  logic          neg_q, neg_d;
  logic [DW-1:0] dist_q, dist_d;
  logic [DW-1:0] cnt_q, cnt_d;

  offset_t off;
  int      nbr_row, nbr_col;
  logic    in_bounds, match;

  // Scan counters; cleared asynchronously so a reset mid-scan aborts it.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      dir_q    <= DIR_H;
      neg_q    <= 1'b0;
      dist_q   <= DW'(1);
      cnt_q    <= DW'(1);
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      neg_q    <= neg_d;
      dist_q   <= dist_d;
      cnt_q    <= cnt_d;
    end
  end

  // Neighbour coordinate, bounds test and board read address.
  always_comb begin
    off       = dir_offset(dir_q);
    nbr_row   = int'(origin_row_i) + (neg_q ? -1 : 1) * int'(off.drow) * int'(dist_q);
    nbr_col   = int'(origin_col_i) + (neg_q ? -1 : 1) * int'(off.dcol) * int'(dist_q);
    in_bounds = (nbr_row >= 0) && (nbr_row < BOARD_H) && (nbr_col >= 0) && (nbr_col < BOARD_W);
    rd_addr_o = in_bounds ? AW'(nbr_row * BOARD_W + nbr_col) : '0;
    match     = active_q && in_bounds && (rd_data_i == colour_i);
  end

  // Advance offset / half / direction and flag the end of the scan.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    active_d = active_q;
    dir_d    = dir_q;
    neg_d    = neg_q;
    dist_d   = dist_q;
    cnt_d    = cnt_q;
    done_o   = 1'b0;
    win_o    = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      dir_d    = DIR_H;
      neg_d    = 1'b0;
      dist_d   = DW'(1);
      cnt_d    = DW'(1);
    end else if (active_q) begin
      if (match) begin
        if (int'(cnt_q) + 1 >= WIN_LEN) begin
          done_o   = 1'b1;
          win_o    = 1'b1;
          active_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          dist_d = dist_q + 1'b1;
        end
      end else if (!neg_q) begin
        neg_d  = 1'b1;
        dist_d = DW'(1);
      end else if (dir_q == DIR_A) begin
        done_o   = 1'b1;
        active_d = 1'b0;
      end else begin
        dir_d  = dir_t'(dir_q + 2'd1);
        neg_d  = 1'b0;
        dist_d = DW'(1);
        cnt_d  = DW'(1);
      end
    end
  end

endmodule

// File: rtl/board_game_fsm.sv
// Turn-based gomoku board controller: cursor, stone placement, alternating
// player, sequential win/draw check and game-over with restart.
// Optional feature: define BOARD_GAME_CURSOR_WRAP_EN to make the cursor wrap
// at the board edges instead of clamping.
module board_game_fsm
  import board_game_pkg::*;
#(
  parameter int BOARD_W = 6,
  parameter int BOARD_H = 6,
  parameter int WIN_LEN = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           up,
  input  logic                           down,
  input  logic                           left,
  input  logic                           right,
  input  logic                           center,
  output logic [2*BOARD_W*BOARD_H-1:0]   board,
  output logic [1:0]                     player,
  output logic [$clog2(BOARD_H)-1:0]     cursor_row,
  output logic [$clog2(BOARD_W)-1:0]     cursor_col,
  output logic                           busy,
  output logic                           game_over,
  output logic [1:0]                     winner
);

  localparam int N  = BOARD_W * BOARD_H;
  localparam int RW = $clog2(BOARD_H);
  localparam int CW = $clog2(BOARD_W);
  localparam int AW = $clog2(N);
  localparam int SW = $clog2(N + 1);

  state_t        state_q, state_d;
  cell_t         board_q [N];
  cell_t         board_d [N];
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  cell_t         player_q, player_d;
  cell_t         winner_q, winner_d;
  logic [SW-1:0] stones_q, stones_d;

  logic [AW-1:0] cur_idx;
  logic [AW-1:0] scan_addr;
  logic          scan_start, scan_done, scan_win;

  assign cur_idx = AW'(int'(row_q) * BOARD_W + int'(col_q));

  // The cursor cannot move while checking, so it still marks the placed cell.
  win_scanner #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .WIN_LEN (WIN_LEN),
    .RW      (RW),
    .CW      (CW),
    .AW      (AW)
  ) u_scanner (
    .clk          (clk),
    .rst          (rst),
    .start_i      (scan_start),
    .origin_row_i (row_q),
    .origin_col_i (col_q),
    .colour_i     (player_q),
    .rd_data_i    (board_q[scan_addr]),
    .rd_addr_o    (scan_addr),
    .done_o       (scan_done),
    .win_o        (scan_win)
  );

  // State register together with board, cursor, player, stone count and winner.
  // NOTE: the board array is reset on purpose: the renderer displays it
  // straight after reset and it has to read as all-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PLAY;
      board_q  <= '{default: EMPTY};
      row_q    <= '0;
      col_q    <= '0;
      player_q <= BLACK;
      winner_q <= EMPTY;
      stones_q <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      row_q    <= row_d;
      col_q    <= col_d;
      player_q <= player_d;
      winner_q <= winner_d;
      stones_q <= stones_d;
    end
  end

  // Next state: placement, cursor moves, check outcome and restart.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    row_d      = row_q;
    col_d      = col_q;
    player_d   = player_q;
    winner_d   = winner_q;
    stones_d   = stones_q;
    scan_start = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (center && board_q[cur_idx] == EMPTY) begin
          board_d[cur_idx] = player_q;
          stones_d         = stones_q + 1'b1;
          scan_start       = 1'b1;
          state_d          = CHECK;
        end else if (left) begin
          if (col_q != '0) col_d = col_q - 1'b1;
`ifdef BOARD_GAME_CURSOR_WRAP_EN
          else             col_d = CW'(BOARD_W - 1);
`endif
        end else if (right) begin
          if (col_q != CW'(BOARD_W - 1)) col_d = col_q + 1'b1;
`ifdef BOARD_GAME_CURSOR_WRAP_EN
          else                           col_d = '0;
`endif
        end else if (up) begin
          if (row_q != '0) row_d = row_q - 1'b1;
`ifdef BOARD_GAME_CURSOR_WRAP_EN
          else             row_d = RW'(BOARD_H - 1);
`endif
        end else if (down) begin
          if (row_q != RW'(BOARD_H - 1)) row_d = row_q + 1'b1;
`ifdef BOARD_GAME_CURSOR_WRAP_EN
          else                           row_d = '0;
`endif
        end
      end
      CHECK: begin
        if (scan_done) begin
          if (scan_win) begin
            winner_d = player_q;
            state_d  = OVER;
          end else if (int'(stones_q) == N) begin
            winner_d = DRAW;
            state_d  = OVER;
          end else begin
            player_d = (player_q == BLACK) ? WHITE : BLACK;
            state_d  = PLAY;
          end
        end
      end
      OVER: begin
        if (center) begin
          board_d  = '{default: EMPTY};
          row_d    = '0;
          col_d    = '0;
          player_d = BLACK;
          winner_d = EMPTY;
          stones_d = '0;
          state_d  = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // Outputs to the renderer: packed board and status flags.
  always_comb begin
    board = '0;
    for (int i = 0; i < N; i++) board[2*i +: 2] = board_q[i];
    player     = player_q;
    cursor_row = row_q;
    cursor_col = col_q;
    busy       = (state_q == CHECK);
    game_over  = (state_q == OVER);
    winner     = winner_q;
  end

endmodule

// File: tb/tb_board_game_fsm.sv
// Self-checking bench for board_game_fsm (6x6, five in a row): directed games
// with literal expectations plus random button traffic, all compared every
// cycle against a game-level model.
`timescale 1ns/1ps
module tb_board_game_fsm;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int WL = 5;
  localparam int N  = W * H;
`ifdef BOARD_GAME_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [4:0] B_L = 5'b10000;
  localparam logic [4:0] B_R = 5'b01000;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_C = 5'b00001;

  logic           clk = 1'b0;
  logic           rst;
  logic           up, down, left, right, center;
  logic [2*N-1:0] board;
  logic [1:0]     player;
  logic [2:0]     cursor_row, cursor_col;
  logic           busy, game_over;
  logic [1:0]     winner;

  board_game_fsm #(.BOARD_W(W), .BOARD_H(H), .WIN_LEN(WL)) dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .center     (center),
    .board      (board),
    .player     (player),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- game-level model ----------------
  int m_cell [N];
  int m_row, m_col, m_player, m_winner, m_stones, m_left;
  bit m_over, m_win_pending;

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_cell[i] = 0;
    m_row = 0; m_col = 0; m_player = 1; m_winner = 0;
    m_stones = 0; m_left = 0; m_over = 0; m_win_pending = 0;
  endtask

  // Outcome of a placement and how many checker cycles it takes: each half-line
  // costs its run length plus one, or only the stones needed to reach WL.
  task automatic m_scan(input int r, input int c, input int colr, output bit win, output int len);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    win = 1'b0;
    len = 0;
    for (int d = 0; d < 4 && !win; d++) begin
      int cnt;
      cnt = 1;
      for (int h = 0; h < 2 && !win; h++) begin
        int s, m, rr, cc;
        s = (h == 0) ? 1 : -1;
        m = 0;
        while (cnt + m < WL) begin
          rr = r + s * dr[d] * (m + 1);
          cc = c + s * dc[d] * (m + 1);
          if (rr < 0 || rr >= H || cc < 0 || cc >= W) break;
          if (m_cell[rr*W + cc] != colr) break;
          m++;
        end
        if (cnt + m >= WL) begin
          win = 1'b1;
          len += WL - cnt;
        end else begin
          len += m + 1;
          cnt += m;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_win_pending) begin
          m_over = 1; m_winner = m_player;
        end else if (m_stones == N) begin
          m_over = 1; m_winner = 3;
        end else begin
          m_player = 3 - m_player;
        end
      end
    end else if (m_over) begin
      if (center) m_reset();
    end else if (center && m_cell[m_row*W + m_col] == 0) begin
      m_cell[m_row*W + m_col] = m_player;
      m_stones++;
      m_scan(m_row, m_col, m_player, m_win_pending, m_left);
    end else if (left) begin
      if (m_col > 0) m_col--; else if (WRAP) m_col = W - 1;
    end else if (right) begin
      if (m_col < W - 1) m_col++; else if (WRAP) m_col = 0;
    end else if (up) begin
      if (m_row > 0) m_row--; else if (WRAP) m_row = H - 1;
    end else if (down) begin
      if (m_row < H - 1) m_row++; else if (WRAP) m_row = 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [2*N-1:0] exp_board;
    if (cmp_en) begin
      for (int i = 0; i < N; i++) exp_board[2*i +: 2] = 2'(m_cell[i]);
      check("board", board, exp_board);
      check("player", player, m_player);
      check("cursor_row", cursor_row, m_row);
      check("cursor_col", cursor_col, m_col);
      check("busy", busy, m_left > 0);
      check("game_over", game_over, m_over);
      check("winner", winner, m_over ? m_winner : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [4:0] b);
    @(negedge clk);
    {left, right, up, down, center} = b;
  endtask

  task automatic press(input logic [4:0] b);
    step(b);
    step(5'b0);
  endtask

  task automatic goto(input int r, input int c);
    while (m_row != r) press(m_row < r ? B_D : B_U);
    while (m_col != c) press(m_col < c ? B_R : B_L);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("scan_done_in_budget", busy, 1'b0);
  endtask

  task automatic place(input int r, input int c);
    goto(r, c);
    press(B_C);
    wait_idle(64);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    m_reset();
    rst = 1'b1;
    {left, right, up, down, center} = 5'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_board", board, '0);
    check("rst_player", player, 2'b01);
    check("rst_cursor", {cursor_row, cursor_col}, 6'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_game_over", game_over, 1'b0);
    check("rst_winner", winner, 2'b00);
    #2 rst = 1'b0;

    // Cursor edges
    press(B_L);
    check("left_at_col0", cursor_col, WRAP ? 3'd5 : 3'd0);
    goto(0, 0);
    repeat (7) press(B_R);
    check("right_x7", cursor_col, WRAP ? 3'd1 : 3'd5);
    check("right_x7_row", cursor_row, 3'd0);

    // Placement at (2,3) = cell 15
    goto(2, 3);
    press(B_C);
    check("place_cell15", board[31:30], 2'b01);
    check("place_busy", busy, 1'b1);
    wait_idle(64);
    check("player_after_place", player, 2'b10);
    press(B_C);
    check("occupied_cell15", board[31:30], 2'b01);
    check("occupied_busy", busy, 1'b0);
    check("occupied_player", player, 2'b10);

    // Horizontal win for black
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      place(0, i);
      place(5, i);
    end
    goto(0, 4);
    press(B_C);
    wait_idle(40);
    check("hwin_game_over", game_over, 1'b1);
    check("hwin_winner", winner, 2'b01);
    press(B_R);
    press(B_D);
    check("over_cursor_frozen", {cursor_row, cursor_col}, {3'd0, 3'd4});
    press(B_C);
    check("restart_board", board, '0);
    check("restart_player", player, 2'b01);
    check("restart_over", game_over, 1'b0);

    // Anti-diagonal win for white, last stone in the middle
    place(5, 5); place(0, 4);
    place(3, 5); place(1, 3);
    place(5, 2); place(3, 1);
    place(1, 5); place(4, 0);
    place(0, 0); place(2, 2);
    check("adiag_winner", winner, 2'b10);
    check("adiag_player_kept", player, 2'b10);
    press(B_C);

    // Overline of six on the long anti-diagonal
    place(0, 0); place(0, 5);
    place(0, 2); place(1, 4);
    place(2, 0); place(2, 3);
    place(5, 5); place(4, 1);
    place(3, 5); place(5, 0);
    place(5, 3); place(3, 2);
    check("overline_winner", winner, 2'b10);
    press(B_C);

    // Draw: colour (r + c/2) % 2 never forms more than two in a line
    begin
      int bl [$];
      int wh [$];
      for (int i = 0; i < N; i++) begin
        if (((i / W) + ((i % W) / 2)) % 2 == 0) bl.push_back(i);
        else wh.push_back(i);
      end
      for (int k = 0; k < N / 2; k++) begin
        place(bl[k] / W, bl[k] % W);
        place(wh[k] / W, wh[k] % W);
      end
    end
    check("draw_game_over", game_over, 1'b1);
    check("draw_winner", winner, 2'b11);
    press(B_C);
    check("draw_restart_board", board, '0);
    check("draw_restart_player", player, 2'b01);

    // Reset in the middle of a scan
    goto(1, 1);
    press(B_C);
    check("midscan_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midscan_rst_busy", busy, 1'b0);
    check("midscan_rst_board", board, '0);
    check("midscan_rst_player", player, 2'b01);
    check("midscan_rst_cursor", {cursor_row, cursor_col}, 6'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Random button traffic
    for (int i = 0; i < 6000; i++) begin
      logic [4:0] b;
      int r;
      b = 5'b0;
      r = $urandom_range(0, 9);
      if (r < 4) b = 5'b1 << $urandom_range(0, 4);
      else if (r == 4) b = 5'($urandom_range(0, 31));
      step(b);
    end
    step(5'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
